// File: rtl/dcache_sa_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dcache_sa_pkg
//  Purpose  : Shared types and width helpers for the set-associative
//             write-back data cache controller.
//  Revision : 1.0 - initial release
// ============================================================================
package dcache_sa_pkg;

    // Controller states: serve hits, flush a dirty victim, refill a line
    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITEBACK = 2'd1,
        S_ALLOCATE  = 2'd2
    } state_e;

    // Byte-offset width inside one line
    function automatic int unsigned off_w(input int unsigned line_bits);
        return $clog2(line_bits / 8);
    endfunction

    // Set-index width
    function automatic int unsigned idx_w(input int unsigned sets);
        return $clog2(sets);
    endfunction

    // Tag width: whatever the offset and index leave of the address
    function automatic int unsigned tag_w(input int unsigned addr_w,
                                          input int unsigned line_bits,
                                          input int unsigned sets);
        return addr_w - off_w(line_bits) - idx_w(sets);
    endfunction

    // Way-pointer width; a direct-mapped build still keeps one bit
    function automatic int unsigned ptr_w(input int unsigned ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    // Bit position of a 32-bit word inside a line
    function automatic int unsigned word_lsb(input int unsigned word);
        return word * 32;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_sa_victim_sel.sv
`default_nettype none
// ============================================================================
//  Module   : dcache_sa_victim_sel
//  Purpose  : Replacement choice for one set: lowest-index invalid way if
//             any, otherwise the round-robin pointer.
//  Revision : 1.0 - initial release
// ============================================================================
module dcache_sa_victim_sel #(
    parameter int unsigned WAYS  = 2,
    parameter int unsigned PTR_W = 1
) (
    input  logic [WAYS-1:0]  valid_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [PTR_W-1:0] victim_o,
    output logic             victim_valid_o
);

    // Scan high-to-low so the lowest invalid way is the last one to win
    always_comb begin
        victim_o       = ptr_i;
        victim_valid_o = 1'b1;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_i[w]) begin
                victim_o       = PTR_W'(w);
                victim_valid_o = 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dcache_sa_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dcache_sa_ctrl
//  Purpose  : N-way set-associative, write-back, write-allocate data cache
//             controller between the MEM stage and a line-wide memory.
//             Optional macro DCACHE_SA_PERF_EN adds hit/miss/writeback
//             counters on hit_cnt_o, miss_cnt_o and wb_cnt_o.
//  Revision : 1.0 - initial release
// ============================================================================
module dcache_sa_ctrl
    import dcache_sa_pkg::*;
#(
    parameter int unsigned WAYS      = 2,
    parameter int unsigned SETS      = 16,
    parameter int unsigned LINE_BITS = 256,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [ADDR_W-1:0]    p1_addr_i,
    input  logic [31:0]          p1_data_i,
    input  logic                 p1_MemRead_i,
    input  logic                 p1_MemWrite_i,
    output logic [31:0]          p1_data_o,
    output logic                 p1_stall_o,
    input  logic [LINE_BITS-1:0] mem_data_i,
    input  logic                 mem_ack_i,
    output logic [LINE_BITS-1:0] mem_data_o,
    output logic [ADDR_W-1:0]    mem_addr_o,
    output logic                 mem_enable_o,
    output logic                 mem_write_o
`ifdef DCACHE_SA_PERF_EN
    ,
    output logic [31:0]          hit_cnt_o,
    output logic [31:0]          miss_cnt_o,
    output logic [31:0]          wb_cnt_o
`endif
);

    localparam int unsigned c_OFF_W  = off_w(LINE_BITS);
    localparam int unsigned c_IDX_W  = idx_w(SETS);
    localparam int unsigned c_TAG_W  = tag_w(ADDR_W, LINE_BITS, SETS);
    localparam int unsigned c_PTR_W  = ptr_w(WAYS);
    localparam int unsigned c_WORD_W = c_OFF_W - 2;

    // Address fields of the current request
    logic [c_TAG_W-1:0]  w_req_tag;
    logic [c_IDX_W-1:0]  w_req_idx;
    logic [c_WORD_W-1:0] w_req_word;
    logic [ADDR_W-1:0]   w_fill_addr;
    logic                w_req;
    logic                w_unused;

    assign w_req_tag   = p1_addr_i[ADDR_W-1 -: c_TAG_W];
    assign w_req_idx   = p1_addr_i[c_OFF_W +: c_IDX_W];
    assign w_req_word  = p1_addr_i[2 +: c_WORD_W];
    assign w_fill_addr = {w_req_tag, w_req_idx, {c_OFF_W{1'b0}}};
    assign w_req       = p1_MemRead_i | p1_MemWrite_i;
    assign w_unused    = &{1'b0, p1_addr_i[1:0]};

    // Cache storage; lines and tags carry no reset
    logic [LINE_BITS-1:0] line_q  [WAYS][SETS];
    logic [c_TAG_W-1:0]   tag_q   [WAYS][SETS];
    logic [WAYS-1:0]      valid_q [SETS];
    logic [WAYS-1:0]      dirty_q [SETS];
    logic [c_PTR_W-1:0]   ptr_q   [SETS];

    // Controller registers
    state_e               state_q,    state_d;
    logic [c_PTR_W-1:0]   victim_q,   victim_d;
    logic                 mem_en_q,   mem_en_d;
    logic                 mem_wr_q,   mem_wr_d;
    logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
    logic [LINE_BITS-1:0] mem_data_q, mem_data_d;

    // Parallel tag compare
    logic [WAYS-1:0]      w_hit_vec;
    logic [c_PTR_W-1:0]   w_hit_way;
    logic                 w_hit;
    logic [LINE_BITS-1:0] w_hit_line;
    logic [31:0]          w_hit_word;

    for (genvar gw = 0; gw < WAYS; gw++) begin : g_way
        assign w_hit_vec[gw] = valid_q[w_req_idx][gw] &&
                               (tag_q[gw][w_req_idx] == w_req_tag);
    end

    // Encode the single matching way
    always_comb begin
        w_hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (w_hit_vec[w]) w_hit_way = c_PTR_W'(w);
        end
    end

    assign w_hit      = |w_hit_vec;
    assign w_hit_line = line_q[w_hit_way][w_req_idx];
    assign w_hit_word = w_hit_line[word_lsb(32'(w_req_word)) +: 32];

    // Victim choice for the requested set
    logic [c_PTR_W-1:0] w_victim;
    logic               w_victim_valid;
    logic [c_PTR_W-1:0] w_ptr_next;

    dcache_sa_victim_sel #(
        .WAYS  (WAYS),
        .PTR_W (c_PTR_W)
    ) u_victim_sel (
        .valid_i        (valid_q[w_req_idx]),
        .ptr_i          (ptr_q[w_req_idx]),
        .victim_o       (w_victim),
        .victim_valid_o (w_victim_valid)
    );

    assign w_ptr_next = (ptr_q[w_req_idx] == c_PTR_W'(WAYS - 1)) ? '0
                        : ptr_q[w_req_idx] + c_PTR_W'(1);

    // Event strobes for the storage update
    logic w_store_hit;
    logic w_miss;
    logic w_wb_done;
    logic w_fill_done;

    // Next-state and next-memory-request computation
    always_comb begin
        state_d     = state_q;
        victim_d    = victim_q;
        mem_en_d    = mem_en_q;
        mem_wr_d    = mem_wr_q;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        w_store_hit = 1'b0;
        w_miss      = 1'b0;
        w_wb_done   = 1'b0;
        w_fill_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_req && w_hit) begin
                    w_store_hit = p1_MemWrite_i;
                end else if (w_req) begin
                    w_miss   = 1'b1;
                    victim_d = w_victim;
                    mem_en_d = 1'b1;
                    if (w_victim_valid && dirty_q[w_req_idx][w_victim]) begin
                        state_d    = S_WRITEBACK;
                        mem_wr_d   = 1'b1;
                        mem_addr_d = {tag_q[w_victim][w_req_idx], w_req_idx,
                                      {c_OFF_W{1'b0}}};
                        mem_data_d = line_q[w_victim][w_req_idx];
                    end else begin
                        state_d    = S_ALLOCATE;
                        mem_wr_d   = 1'b0;
                        mem_addr_d = w_fill_addr;
                        mem_data_d = '0;
                    end
                end
            end
            S_WRITEBACK: begin
                if (mem_ack_i) begin
                    w_wb_done  = 1'b1;
                    state_d    = S_ALLOCATE;
                    mem_wr_d   = 1'b0;
                    mem_addr_d = w_fill_addr;
                    mem_data_d = '0;
                end
            end
            S_ALLOCATE: begin
                if (mem_ack_i) begin
                    w_fill_done = 1'b1;
                    state_d     = S_IDLE;
                    mem_en_d    = 1'b0;
                    mem_wr_d    = 1'b0;
                    mem_addr_d  = '0;
                    mem_data_d  = '0;
                end
            end
            default: begin
                state_d  = S_IDLE;
                mem_en_d = 1'b0;
                mem_wr_d = 1'b0;
            end
        endcase
    end

    // FSM state and registered memory-side outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            victim_q   <= '0;
            mem_en_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
        end else begin
            state_q    <= state_d;
            victim_q   <= victim_d;
            mem_en_q   <= mem_en_d;
            mem_wr_q   <= mem_wr_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
        end
    end

    // Valid, dirty and replacement pointer bookkeeping
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                ptr_q[s]   <= '0;
            end
        end else begin
            if (w_store_hit) dirty_q[w_req_idx][w_hit_way] <= 1'b1;
            if (w_wb_done)   dirty_q[w_req_idx][victim_q]  <= 1'b0;
            if (w_fill_done) begin
                valid_q[w_req_idx][victim_q] <= 1'b1;
                dirty_q[w_req_idx][victim_q] <= 1'b0;
                ptr_q[w_req_idx]             <= w_ptr_next;
            end
        end
    end

    // Line data and tags: store merge on hit, whole-line refill on ack
    always_ff @(posedge clk_i) begin
        if (w_store_hit) begin
            line_q[w_hit_way][w_req_idx][word_lsb(32'(w_req_word)) +: 32] <= p1_data_i;
        end
        if (w_fill_done) begin
            line_q[victim_q][w_req_idx] <= mem_data_i;
            tag_q[victim_q][w_req_idx]  <= w_req_tag;
        end
    end

    assign p1_stall_o   = (state_q != S_IDLE) || (w_req && !w_hit);
    assign p1_data_o    = (p1_MemRead_i && !p1_stall_o) ? w_hit_word : 32'd0;
    assign mem_enable_o = mem_en_q;
    assign mem_write_o  = mem_wr_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = mem_data_q;

`ifdef DCACHE_SA_PERF_EN
    logic        replay_q,   replay_d;
    logic [31:0] hit_cnt_q,  hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;
    logic [31:0] wb_cnt_q,   wb_cnt_d;

    // Counter increments; the replay after a refill is not a real hit
    always_comb begin
        replay_d   = w_fill_done;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        wb_cnt_d   = wb_cnt_q;
        if ((state_q == S_IDLE) && w_req && w_hit && !replay_q) hit_cnt_d = hit_cnt_q + 32'd1;
        if (w_miss)    miss_cnt_d = miss_cnt_q + 32'd1;
        if (w_wb_done) wb_cnt_d   = wb_cnt_q + 32'd1;
    end

    // Counter registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            replay_q   <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            wb_cnt_q   <= '0;
        end else begin
            replay_q   <= replay_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            wb_cnt_q   <= wb_cnt_d;
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
    assign wb_cnt_o   = wb_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dcache_sa_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dcache_sa_ctrl
//  Purpose  : Self-checking bench for dcache_sa_ctrl: directed scenarios and
//             random loads/stores against a behavioural cache and memory model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dcache_sa_ctrl;

    localparam int unsigned c_WAYS = 2;
    localparam int unsigned c_SETS = 16;
    localparam int unsigned c_LB   = 256;
    localparam int unsigned c_AW   = 32;

    logic            clk = 1'b0;
    logic            rst_i = 1'b1;
    logic [31:0]     p1_addr_i = '0;
    logic [31:0]     p1_data_i = '0;
    logic            p1_MemRead_i = 1'b0;
    logic            p1_MemWrite_i = 1'b0;
    logic [31:0]     p1_data_o;
    logic            p1_stall_o;
    logic [c_LB-1:0] mem_data_i = '0;
    logic            mem_ack_i = 1'b0;
    logic [c_LB-1:0] mem_data_o;
    logic [31:0]     mem_addr_o;
    logic            mem_enable_o;
    logic            mem_write_o;
`ifdef DCACHE_SA_PERF_EN
    logic [31:0]     hit_cnt_o, miss_cnt_o, wb_cnt_o;
`endif

    dcache_sa_ctrl #(
        .WAYS(c_WAYS), .SETS(c_SETS), .LINE_BITS(c_LB), .ADDR_W(c_AW)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .p1_addr_i    (p1_addr_i),
        .p1_data_i    (p1_data_i),
        .p1_MemRead_i (p1_MemRead_i),
        .p1_MemWrite_i(p1_MemWrite_i),
        .p1_data_o    (p1_data_o),
        .p1_stall_o   (p1_stall_o),
        .mem_data_i   (mem_data_i),
        .mem_ack_i    (mem_ack_i),
        .mem_data_o   (mem_data_o),
        .mem_addr_o   (mem_addr_o),
        .mem_enable_o (mem_enable_o),
        .mem_write_o  (mem_write_o)
`ifdef DCACHE_SA_PERF_EN
        ,
        .hit_cnt_o    (hit_cnt_o),
        .miss_cnt_o   (miss_cnt_o),
        .wb_cnt_o     (wb_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: cache contents, replacement pointers, backing memory
    bit              m_valid [c_WAYS][c_SETS];
    bit              m_dirty [c_WAYS][c_SETS];
    int unsigned     m_tag   [c_WAYS][c_SETS];
    logic [c_LB-1:0] m_line  [c_WAYS][c_SETS];
    int unsigned     m_ptr   [c_SETS];
    logic [c_LB-1:0] mem_m   [bit [31:0]];
    logic [31:0]     m_hits, m_misses, m_wbs;
    logic [c_LB-1:0] last_wb;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [c_LB-1:0] got, input logic [c_LB-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned set_of(input logic [31:0] a);  return (a >> 5) % c_SETS; endfunction
    function automatic int unsigned tag_of(input logic [31:0] a);  return a >> 9;            endfunction
    function automatic int unsigned word_of(input logic [31:0] a); return (a >> 2) % 8;      endfunction

    function automatic logic [c_LB-1:0] rand_line();
        logic [c_LB-1:0] l;
        for (int k = 0; k < 8; k++) l[k*32 +: 32] = $urandom;
        return l;
    endfunction

    function automatic logic [c_LB-1:0] mem_read(input logic [31:0] la);
        if (!mem_m.exists(la)) mem_m[la] = rand_line();
        return mem_m[la];
    endfunction

    task automatic model_reset();
        for (int w = 0; w < c_WAYS; w++)
            for (int s = 0; s < c_SETS; s++) begin
                m_valid[w][s] = 1'b0;
                m_dirty[w][s] = 1'b0;
            end
        for (int s = 0; s < c_SETS; s++) m_ptr[s] = 0;
        m_hits = 0; m_misses = 0; m_wbs = 0;
    endtask

    // Act as memory for one transaction; starts #1 after the edge that raised the request
    task automatic serve_mem(input bit wr, input logic [31:0] addr,
                             input logic [c_LB-1:0] data, output logic [c_LB-1:0] seen);
        int unsigned lat = $urandom_range(0, 3);
        repeat (lat) begin
            @(posedge clk); #1;
        end
        check("mem_en",    {255'd0, mem_enable_o}, 256'd1);
        check("mem_write", {255'd0, mem_write_o}, {255'd0, wr});
        check("mem_addr",  {224'd0, mem_addr_o}, {224'd0, addr});
        check("mem_dout",  mem_data_o, wr ? data : '0);
        check("wait_stall", {255'd0, p1_stall_o}, 256'd1);
        seen       = mem_data_o;
        mem_data_i = wr ? '0 : data;
        mem_ack_i  = 1'b1;
        @(posedge clk); #1;
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
    endtask

    // One load or store, held until satisfied; starts and ends #1 after a clock edge
    task automatic do_access(input bit wr, input logic [31:0] addr, input logic [31:0] wdata);
        int unsigned s  = set_of(addr);
        int unsigned t  = tag_of(addr);
        int unsigned wd = word_of(addr);
        int way = -1;
        int v;
        logic [c_LB-1:0] seen;
        logic [31:0] la = addr & 32'hFFFF_FFE0;
        p1_addr_i = addr; p1_data_i = wdata;
        p1_MemWrite_i = wr; p1_MemRead_i = !wr;
        #1;
        for (int w = 0; w < c_WAYS; w++)
            if (m_valid[w][s] && m_tag[w][s] == t) way = w;
        if (way >= 0) begin
            m_hits++;
            check("hit_stall", {255'd0, p1_stall_o}, 256'd0);
            if (!wr) check("hit_data", {224'd0, p1_data_o}, {224'd0, m_line[way][s][wd*32 +: 32]});
            check("hit_no_mem", {255'd0, mem_enable_o}, 256'd0);
            @(posedge clk); #1;
        end else begin
            m_misses++;
            check("miss_stall", {255'd0, p1_stall_o}, 256'd1);
            v = -1;
            for (int w = c_WAYS - 1; w >= 0; w--) if (!m_valid[w][s]) v = w;
            if (v < 0) v = int'(m_ptr[s]);
            @(posedge clk); #1;
            if (m_valid[v][s] && m_dirty[v][s]) begin
                serve_mem(1'b1, (m_tag[v][s] << 9) | (s << 5), m_line[v][s], seen);
                last_wb = seen;
                mem_m[(m_tag[v][s] << 9) | (s << 5)] = m_line[v][s];
                m_dirty[v][s] = 1'b0;
                m_wbs++;
            end
            serve_mem(1'b0, la, mem_read(la), seen);
            m_line[v][s]  = mem_m[la];
            m_tag[v][s]   = t;
            m_valid[v][s] = 1'b1;
            m_dirty[v][s] = 1'b0;
            m_ptr[s]      = (m_ptr[s] + 1) % c_WAYS;
            way = v;
            check("replay_stall", {255'd0, p1_stall_o}, 256'd0);
            if (!wr) check("replay_data", {224'd0, p1_data_o}, {224'd0, m_line[way][s][wd*32 +: 32]});
            @(posedge clk); #1;
        end
        if (wr) begin
            m_line[way][s][wd*32 +: 32] = wdata;
            m_dirty[way][s] = 1'b1;
        end
        p1_MemRead_i = 1'b0; p1_MemWrite_i = 1'b0;
    endtask

    task automatic idle_check(input string tag);
        p1_MemRead_i = 1'b0; p1_MemWrite_i = 1'b0;
        #1;
        check({tag, "_stall"}, {255'd0, p1_stall_o}, 256'd0);
        check({tag, "_data"},  {224'd0, p1_data_o}, 256'd0);
        check({tag, "_en"},    {255'd0, mem_enable_o}, 256'd0);
        check({tag, "_addr"},  {224'd0, mem_addr_o}, 256'd0);
        check({tag, "_mdata"}, mem_data_o, 256'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [c_LB-1:0] l;
        logic [31:0] a;
        logic [31:0] last_a;
        model_reset();
        last_wb = '0;

        // Reset
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
        check("rst_write", {255'd0, mem_write_o}, 256'd0);
        idle_check("rst");

        // Cold read miss with a known word 0
        l = rand_line(); l[31:0] = 32'h1234_5678;
        mem_m[32'h40] = l;
        do_access(1'b0, 32'h40, 32'd0);
        do_access(1'b0, 32'h44, 32'd0);

        // Store hit, then read back
        do_access(1'b1, 32'h40, 32'hDEAD_BEEF);
        do_access(1'b0, 32'h40, 32'd0);
        idle_check("post_store");

        // Same-set conflict forces writeback of the dirty line
        do_access(1'b0, 32'h240, 32'd0);
        do_access(1'b0, 32'h440, 32'd0);
        check("wb_beef", {224'd0, last_wb[31:0]}, {224'd0, 32'hDEAD_BEEF});

        // Write miss: refill then merge on replay
        do_access(1'b1, 32'h80, 32'hCAFE_F00D);
        do_access(1'b0, 32'h84, 32'd0);
        do_access(1'b0, 32'h80, 32'd0);

        // Reset while the refill is outstanding; the ack arrives late
        p1_addr_i = 32'h1000; p1_MemRead_i = 1'b1;
        #1 check("rm_stall", {255'd0, p1_stall_o}, 256'd1);
        @(posedge clk); #1;
        check("rm_alloc_en", {255'd0, mem_enable_o}, 256'd1);
        check("rm_alloc_wr", {255'd0, mem_write_o}, 256'd0);
        rst_i = 1'b1; p1_MemRead_i = 1'b0;
        @(posedge clk); #1;
        rst_i = 1'b0;
        model_reset();
        check("rm_en_off", {255'd0, mem_enable_o}, 256'd0);
        @(posedge clk); #1;
        mem_data_i = rand_line(); mem_ack_i = 1'b1;
        @(posedge clk); #1;
        mem_ack_i = 1'b0; mem_data_i = '0;
        idle_check("late_ack");
        do_access(1'b0, 32'h40, 32'd0);

        // Random loads and stores over a few conflicting tags and sets
        last_a = 32'h40;
        for (int n = 0; n < 300; n++) begin
            a = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 3) << 5) | ($urandom_range(0, 7) << 2);
            if ($urandom_range(0, 9) == 0) idle_check("rnd_idle");
            do_access($urandom_range(0, 1) == 1, a, $urandom);
            last_a = a;
        end

`ifdef DCACHE_SA_PERF_EN
        check("cnt_hit",  {224'd0, hit_cnt_o},  {224'd0, m_hits});
        check("cnt_miss", {224'd0, miss_cnt_o}, {224'd0, m_misses});
        check("cnt_wb",   {224'd0, wb_cnt_o},   {224'd0, m_wbs});
        force dut.hit_cnt_q = 32'hFFFF_FFFF;
        #1 release dut.hit_cnt_q;
        m_hits = 32'hFFFF_FFFF;
        do_access(1'b0, last_a, 32'd0);
        check("cnt_wrap", {224'd0, hit_cnt_o}, {224'd0, m_hits});
`else
        do_access(1'b0, last_a, 32'd0);
`endif
        idle_check("end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
